adder_arbiter: RTL

- Shares one registered 8-bit adder (valid_in/a/b in, valid_out/c out, fixed ADD_LAT-cycle latency, no backpressure) between N_REQ requesters.
- Round-robin arbitration with per-requester valid/ready request and response handshakes.
- Tags each issued operation, tracks it through the adder latency, and parks each sum in a per-requester result slot until the requester drains it.
- Sits between requester agents and the adder instance in the example top level.

---
 rtl/adder_arb_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/adder_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared configuration and types for the adder arbiter and its sub-module.
// N_REQ and DATA_W are set here so that every file sees the same tag and
// operand layouts.
package adder_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 1;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // One entry of the in-flight tag pipeline: which requester owns the sum.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Operand pair presented to the shared adder.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    // Index of the set bit of a one-hot (or zero) vector; zero when empty.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: combinational one-hot grant of the first
// eligible index at or after the pointer, pointer moves past the winner
// whenever the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  eligible_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] ptr_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] sel;
    logic          found;
    int            cand;

    // Scan from the pointer, wrapping, and grant the first eligible index.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        grant_o = '0;
        sel     = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr_q) + off) % N;
            if (!found && eligible_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                sel           = IW'(cand);
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (int'(sel) == N - 1) ? '0 : sel + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops
        // sample pre-edge values regardless of statement order.
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder between N_REQ requesters: round-robin issue,
// tag tracking through the adder latency, and per-requester result slots
// that hold each sum until the requester drains it.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int ADD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [N_REQ*SUM_W-1:0]  rsp_sum,
    output logic                    add_valid_in,
    output logic [DATA_W-1:0]       add_a,
    output logic [DATA_W-1:0]       add_b,
    input  logic                    add_valid_out,
    input  logic [SUM_W-1:0]        add_c,
    output logic                    busy,
    output logic                    protocol_err
);

    logic [N_REQ-1:0] eligible, grant, drain;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx, rr_ptr;

    logic [N_REQ-1:0] reserved_q, reserved_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [SUM_W-1:0] slot_q [N_REQ];
    logic [SUM_W-1:0] slot_d [N_REQ];
    tag_t             issue_q, issue_d;
    op_t              op_q, op_d;
    logic             err_q, err_d;

    tag_t             tag_pipe_q [ADD_LAT];
    tag_t             tag_out;
    logic             mismatch, capture;

    // A requester with a reserved slot cannot request again until it drains.
    assign eligible  = req_valid & ~reserved_q;
    assign grant_any = |grant;
    assign grant_idx = onehot_to_idx(grant);
    assign drain     = rsp_valid_q & rsp_ready;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .eligible_i (eligible),
        .advance_i  (grant_any),
        .grant_o    (grant),
        .ptr_o      (rr_ptr)
    );

    assign tag_out  = tag_pipe_q[ADD_LAT-1];
    assign mismatch = (add_valid_out != tag_out.valid);
    assign capture  = tag_out.valid & add_valid_out;

    // Next-state for issue stage, reservations, result slots and error flag.
    always_comb begin
        issue_d.valid = grant_any;
        issue_d.idx   = grant_idx;
        op_d          = op_q;
        if (grant_any) begin
            op_d.a = req_a[int'(grant_idx)*DATA_W +: DATA_W];
            op_d.b = req_b[int'(grant_idx)*DATA_W +: DATA_W];
        end

        reserved_d  = (reserved_q | grant) & ~drain;
        rsp_valid_d = rsp_valid_q & ~drain;
        slot_d      = slot_q;
        if (capture) begin
            slot_d[tag_out.idx]      = add_c;
            rsp_valid_d[tag_out.idx] = 1'b1;
        end

        err_d = err_q | mismatch;
    end

    // State registers for issue, slots, reservations and the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q     <= '0;
            op_q        <= '0;
            reserved_q  <= '0;
            rsp_valid_q <= '0;
            err_q       <= 1'b0;
            // NOTE: the result slots are reset because rsp_sum is a visible
            // output that must read zero after reset; they are few and small.
            for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
        end else begin
            issue_q     <= issue_d;
            op_q        <= op_d;
            reserved_q  <= reserved_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            slot_q      <= slot_d;
        end
    end

    // Tag shift register aligned with the adder's valid_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < ADD_LAT; s++) tag_pipe_q[s] <= '0;
        end else begin
            tag_pipe_q[0] <= issue_q;
            for (int s = 1; s < ADD_LAT; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
        end
    end

    // Flatten the result slots onto the packed response bus.
    always_comb begin
        rsp_sum = '0;
        for (int i = 0; i < N_REQ; i++) rsp_sum[i*SUM_W +: SUM_W] = slot_q[i];
    end

    assign req_ready    = grant;
    assign rsp_valid    = rsp_valid_q;
    assign add_valid_in = issue_q.valid;
    assign add_a        = op_q.a;
    assign add_b        = op_q.b;
    assign busy         = |reserved_q;
    assign protocol_err = err_q;

    // The reservation rule guarantees a slot is empty when its sum arrives.
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
        capture |-> !rsp_valid_q[tag_out.idx]);

    // The round-robin pointer never leaves the requester range.
    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
        int'(rr_ptr) < N_REQ);

endmodule
